// File: rtl/carregador_memoria_if.sv
// rtl/carregador_memoria_if.sv - program word stream and memoria port bundle
// master: the loader side; slave: the stream source / memory side.
interface carregador_memoria_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) ();
  logic [DATA_W-1:0] DadoIn;
  logic              DadoValido;
  logic              UltimoDado;
  logic              DadoPronto;
  logic              EscMem;
  logic [ADDR_W-1:0] Endereco;
  logic [DATA_W-1:0] ValorEscrito;
  logic [DATA_W-1:0] ValorLido;

  modport master (
    input  DadoIn, DadoValido, UltimoDado, ValorLido,
    output DadoPronto, EscMem, Endereco, ValorEscrito
  );

  modport slave (
    output DadoIn, DadoValido, UltimoDado, ValorLido,
    input  DadoPronto, EscMem, Endereco, ValorEscrito
  );
endinterface

// File: rtl/carregador_memoria.sv
// rtl/carregador_memoria.sv - program loader and run supervisor for mRisc/memoria
// Clears memory, streams a program in, runs the CPU and stops it once the halt opcode drains.
module carregador_memoria #(
  parameter int                ADDR_W     = 16,
  parameter int                DATA_W     = 16,
  parameter bit                CLEAR_MEM  = 1'b1,
  parameter logic [DATA_W-1:0] HALT_INST  = 16'h2fff,
  parameter int                HALT_DELAY = 8
) (
  input  logic                 CLK,
  input  logic                 Reset,
  input  logic                 Start,
  carregador_memoria_if.master bus,
  output logic                 ResetCPU,
  output logic                 Ocupado,
  output logic                 Parado,
  output logic [ADDR_W:0]      Contagem
);

  localparam int                DLY_W    = (HALT_DELAY > 0) ? $clog2(HALT_DELAY + 1) : 1;
  localparam logic [ADDR_W-1:0] TOP_ADDR = '1;

  typedef enum logic [2:0] {
    OCIOSO,
    LIMPA,
    CARREGA,
    EXECUTA,
    ESVAZIA,
    PARADO
  } estado_t;

  estado_t             state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic [DLY_W-1:0]    delay_q, delay_d;
  logic                esc_q, esc_d;
  logic [ADDR_W-1:0]   end_q, end_d;
  logic [DATA_W-1:0]   val_q, val_d;
  logic                pronto_q, pronto_d;
  logic                rcpu_q, rcpu_d;
  logic                ocup_q, ocup_d;
  logic                parado_q, parado_d;
  logic                aceita;

  assign aceita = pronto_q & bus.DadoValido;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q  <= OCIOSO;
      ptr_q    <= '0;
      cnt_q    <= '0;
      delay_q  <= '0;
      esc_q    <= 1'b0;
      end_q    <= '0;
      val_q    <= '0;
      pronto_q <= 1'b0;
      rcpu_q   <= 1'b1;
      ocup_q   <= 1'b0;
      parado_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      delay_q  <= delay_d;
      esc_q    <= esc_d;
      end_q    <= end_d;
      val_q    <= val_d;
      pronto_q <= pronto_d;
      rcpu_q   <= rcpu_d;
      ocup_q   <= ocup_d;
      parado_q <= parado_d;
    end
  end

  // Outputs are registered: each branch computes what the port shows one cycle later.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    delay_d  = delay_q;
    esc_d    = 1'b0;
    end_d    = end_q;
    val_d    = val_q;
    pronto_d = 1'b0;
    rcpu_d   = rcpu_q;
    ocup_d   = ocup_q;
    parado_d = parado_q;

    case (state_q)
      OCIOSO, PARADO: begin
        rcpu_d = 1'b1;
        if (Start) begin
          state_d  = CLEAR_MEM ? LIMPA : CARREGA;
          ocup_d   = 1'b1;
          cnt_d    = '0;
          ptr_d    = '0;
          parado_d = 1'b0;
        end
      end

      LIMPA: begin
        esc_d = 1'b1;
        end_d = ptr_q;
        val_d = '0;
        ptr_d = ptr_q + ADDR_W'(1);
        if (ptr_q == TOP_ADDR) begin
          state_d = CARREGA;
        end
      end

      CARREGA: begin
        pronto_d = 1'b1;
        if (aceita) begin
          esc_d = 1'b1;
          end_d = ptr_q;
          val_d = bus.DadoIn;
          ptr_d = ptr_q + ADDR_W'(1);
          cnt_d = cnt_q + (ADDR_W + 1)'(1);
          // Stop accepting on the flagged word or once the top address is filled.
          if (bus.UltimoDado || (ptr_q == TOP_ADDR)) begin
            pronto_d = 1'b0;
            state_d  = EXECUTA;
          end
        end
      end

      EXECUTA: begin
        rcpu_d = 1'b0;
        ocup_d = 1'b0;
        if (bus.ValorLido == HALT_INST) begin
          delay_d = DLY_W'(HALT_DELAY);
          state_d = ESVAZIA;
        end
      end

      ESVAZIA: begin
        if (delay_q == '0) begin
          state_d  = PARADO;
          rcpu_d   = 1'b1;
          parado_d = 1'b1;
        end else begin
          delay_d = delay_q - DLY_W'(1);
        end
      end

      default: begin
        state_d = OCIOSO;
      end
    endcase
  end

  assign bus.EscMem       = esc_q;
  assign bus.Endereco     = end_q;
  assign bus.ValorEscrito = val_q;
  assign bus.DadoPronto   = pronto_q;
  assign ResetCPU         = rcpu_q;
  assign Ocupado          = ocup_q;
  assign Parado           = parado_q;
  assign Contagem         = cnt_q;

endmodule
